// File: rtl/spi_screen_pkg.sv
// spi_screen_pkg
// Shared definitions for the ST7789 panel controller:
//   - state_t      : sequencing states of the top-level controller
//   - CMD_*        : ST7789 command opcodes used by the bring-up sequence
//   - INIT_LEN     : number of {rs,byte} entries in the init ROM
//   - init_rom()   : the init ROM contents as a lookup function
//   - pixel_value(): test-pattern colour generator (RGB565)
package spi_screen_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_PREPARE,
        ST_WAKEUP,
        ST_SNOOZE,
        ST_INIT,
        ST_PIXELS
    } state_t;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_MADCTL = 8'h36;
    localparam logic [7:0] CMD_COLMOD = 8'h3A;
    localparam logic [7:0] CMD_INVON  = 8'h21;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_DISPON = 8'h29;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    localparam int INIT_LEN = 17;

    // Init ROM entry lookup. Bit 8 is the D/C flag (0 = command, 1 = parameter).
    // The CASET/RASET windows place the 240x135 visible area inside the
    // controller's 320x240 RAM (columns 40..279, rows 53..187).
    function automatic logic [8:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    init_rom = {1'b0, CMD_MADCTL};
            5'd1:    init_rom = {1'b1, 8'h70};
            5'd2:    init_rom = {1'b0, CMD_COLMOD};
            5'd3:    init_rom = {1'b1, 8'h05};
            5'd4:    init_rom = {1'b0, CMD_INVON};
            5'd5:    init_rom = {1'b0, CMD_CASET};
            5'd6:    init_rom = {1'b1, 8'h00};
            5'd7:    init_rom = {1'b1, 8'h28};
            5'd8:    init_rom = {1'b1, 8'h01};
            5'd9:    init_rom = {1'b1, 8'h17};
            5'd10:   init_rom = {1'b0, CMD_RASET};
            5'd11:   init_rom = {1'b1, 8'h00};
            5'd12:   init_rom = {1'b1, 8'h35};
            5'd13:   init_rom = {1'b1, 8'h00};
            5'd14:   init_rom = {1'b1, 8'hBB};
            5'd15:   init_rom = {1'b0, CMD_DISPON};
            5'd16:   init_rom = {1'b0, CMD_RAMWR};
            default: init_rom = {1'b0, CMD_RAMWR};
        endcase
    endfunction

    // Test pattern: coarse x in red, coarse y in green, x^y checkerboard in blue.
    function automatic logic [15:0] pixel_value(input logic [7:0] x, input logic [7:0] y);
        pixel_value = {x[7:3], y[7:2], x[4:0] ^ y[4:0]};
    endfunction

endpackage

// File: rtl/spi_screen_byte_tx.sv
// spi_byte_tx
// Serialises one {rs,byte} pair onto the panel's SPI pins (mode 0, MSB first)
// in a fixed 17-cycle frame:
//   cycle 0..15 : chip select low, each bit gets a low then a high SCK cycle
//   cycle 16    : chip select high, SCK low; a new start is accepted here so
//                 consecutive bytes run back-to-back
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start, rs, tx_byte    : request to send tx_byte with D/C flag rs
//   done                  : high during cycle 16 of a frame
//   lcd_clk, lcd_cs,
//   lcd_rs, lcd_data      : registered panel pins
module spi_byte_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] tx_byte,
    output logic       done,
    output logic       lcd_clk,
    output logic       lcd_cs,
    output logic       lcd_rs,
    output logic       lcd_data
);

    logic       active;
    logic [4:0] phase;
    logic [4:0] phase_next;
    logic [7:0] shift;
    logic       last;
    logic       load;

    assign last       = active && (phase == 5'd16);
    assign load       = start && (!active || last);
    assign phase_next = phase + 5'd1;
    assign done       = last;

    // All pins are registered so the panel sees clean, glitch-free edges.
    // Odd phases raise SCK; each even phase presents the next bit, taken from
    // bit 6 of the shift register before it moves left.
    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            phase    <= 5'd0;
            shift    <= 8'h00;
            lcd_clk  <= 1'b0;
            lcd_cs   <= 1'b1;
            lcd_rs   <= 1'b1;
            lcd_data <= 1'b0;
        end else if (load) begin
            active   <= 1'b1;
            phase    <= 5'd0;
            shift    <= tx_byte;
            lcd_cs   <= 1'b0;
            lcd_clk  <= 1'b0;
            lcd_rs   <= rs;
            lcd_data <= tx_byte[7];
        end else if (last) begin
            active <= 1'b0;
            phase  <= 5'd0;
        end else if (active) begin
            phase <= phase_next;
            if (phase_next == 5'd16) begin
                lcd_cs  <= 1'b1;
                lcd_clk <= 1'b0;
            end else begin
                lcd_clk <= phase_next[0];
                if (!phase_next[0]) begin
                    lcd_data <= shift[6];
                    shift    <= {shift[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_screen.sv
// spi_screen
// Self-running bring-up and test-pattern generator for an ST7789 SPI panel.
// Sequence: hardware reset pulse, settle delay, SLPOUT, snooze delay, init
// ROM, then an endless RGB565 test pattern written into display RAM.
// Ports:
//   clk        : system clock (27 MHz nominal)
//   resetn     : synchronous reset, active HIGH despite the name
//   lcd_resetn : panel hardware reset, active low
//   lcd_clk    : SPI SCK, idle low
//   lcd_cs     : SPI chip select, active low
//   lcd_rs     : 0 = command byte, 1 = parameter/pixel byte
//   lcd_data   : SPI MOSI, MSB first
module spi_screen
    import spi_screen_pkg::*;
#(
    parameter int T_RESET   = 27000,
    parameter int T_PREPARE = 27000,
    parameter int T_SNOOZE  = 27000,
    parameter int H_PIX     = 240,
    parameter int V_PIX     = 135
) (
    input  logic clk,
    input  logic resetn,
    output logic lcd_resetn,
    output logic lcd_clk,
    output logic lcd_cs,
    output logic lcd_rs,
    output logic lcd_data
);

    localparam logic [24:0] RESET_LEN   = 25'(T_RESET);
    localparam logic [24:0] PREPARE_LEN = 25'(T_PREPARE);
    localparam logic [24:0] SNOOZE_LEN  = 25'(T_SNOOZE);
    localparam logic [7:0]  X_LAST      = 8'(H_PIX - 1);
    localparam logic [7:0]  Y_LAST      = 8'(V_PIX - 1);
    localparam logic [4:0]  ROM_LAST    = 5'(INIT_LEN - 1);

    state_t      state;
    state_t      state_next;
    logic [23:0] delay_cnt;
    logic [24:0] delay_len;
    logic        delay_done;
    logic [4:0]  rom_idx;
    logic [4:0]  rom_sel;
    logic [8:0]  rom_word;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  x_next;
    logic [7:0]  y_next;
    logic        x_wrap;
    logic        low_phase;
    logic [15:0] pix_word;
    logic        tx_start;
    logic        tx_rs;
    logic [7:0]  tx_byte;
    logic        tx_done;

    // The delay length depends on which waiting state we are in. A delay is
    // over on the cycle its count reaches length-1, so the following state
    // begins exactly T_* cycles after the delay began.
    always_comb begin
        delay_len = '0;
        case (state)
            ST_RESET:   delay_len = RESET_LEN;
            ST_PREPARE: delay_len = PREPARE_LEN;
            ST_SNOOZE:  delay_len = SNOOZE_LEN;
            default:    delay_len = '0;
        endcase
    end

    assign delay_done = ({1'b0, delay_cnt} + 25'd1) >= delay_len;

    // rom_idx names the entry currently on the wire; the one after it is
    // fetched ahead so it can be launched in the frame's final cycle.
    assign rom_sel  = (state == ST_SNOOZE) ? 5'd0 : rom_idx + 5'd1;
    assign rom_word = init_rom(rom_sel);

    assign x_wrap = (x == X_LAST);
    assign x_next = x_wrap ? 8'd0 : x + 8'd1;
    assign y_next = x_wrap ? ((y == Y_LAST) ? 8'd0 : y + 8'd1) : y;

    // While the low byte of a pixel is on the wire the following launch is
    // the high byte of the next pixel, so its colour comes from the advanced
    // coordinates.
    assign pix_word = low_phase ? pixel_value(x_next, y_next) : pixel_value(x, y);

    // Next-state and byte-launch decode. Every launch happens in the cycle a
    // previous frame finishes (or a delay expires) so the transmitter never
    // idles between bytes of the same phase.
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        tx_rs      = 1'b1;
        tx_byte    = 8'h00;
        case (state)
            ST_RESET: begin
                if (delay_done) state_next = ST_PREPARE;
            end
            ST_PREPARE: begin
                if (delay_done) begin
                    state_next = ST_WAKEUP;
                    tx_start   = 1'b1;
                    tx_rs      = 1'b0;
                    tx_byte    = CMD_SLPOUT;
                end
            end
            ST_WAKEUP: begin
                if (tx_done) state_next = ST_SNOOZE;
            end
            ST_SNOOZE: begin
                if (delay_done) begin
                    state_next = ST_INIT;
                    tx_start   = 1'b1;
                    tx_rs      = rom_word[8];
                    tx_byte    = rom_word[7:0];
                end
            end
            ST_INIT: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    if (rom_idx == ROM_LAST) begin
                        state_next = ST_PIXELS;
                        tx_rs      = 1'b1;
                        tx_byte    = pix_word[15:8];
                    end else begin
                        tx_rs   = rom_word[8];
                        tx_byte = rom_word[7:0];
                    end
                end
            end
            ST_PIXELS: begin
                if (tx_done) begin
                    tx_start = 1'b1;
                    tx_rs    = 1'b1;
                    tx_byte  = low_phase ? pix_word[15:8] : pix_word[7:0];
                end
            end
            default: state_next = ST_RESET;
        endcase
    end

    // State register plus the delay, ROM and pixel counters. The panel reset
    // pin is registered from the next state so it releases on the same edge
    // that leaves RESET and stays released until the next controller reset.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= ST_RESET;
            delay_cnt  <= 24'd0;
            rom_idx    <= 5'd0;
            x          <= 8'd0;
            y          <= 8'd0;
            low_phase  <= 1'b0;
            lcd_resetn <= 1'b0;
        end else begin
            state      <= state_next;
            lcd_resetn <= (state_next != ST_RESET);

            if (state_next != state) begin
                delay_cnt <= 24'd0;
            end else if (state == ST_RESET || state == ST_PREPARE || state == ST_SNOOZE) begin
                delay_cnt <= delay_cnt + 24'd1;
            end

            if (state == ST_SNOOZE && state_next == ST_INIT) begin
                rom_idx <= 5'd0;
            end else if (state == ST_INIT && tx_done && state_next == ST_INIT) begin
                rom_idx <= rom_idx + 5'd1;
            end

            if (state == ST_INIT && state_next == ST_PIXELS) begin
                low_phase <= 1'b0;
            end else if (state == ST_PIXELS && tx_done) begin
                low_phase <= !low_phase;
                if (low_phase) begin
                    x <= x_next;
                    y <= y_next;
                end
            end
        end
    end

    spi_byte_tx u_tx (
        .clk      (clk),
        .reset    (resetn),
        .start    (tx_start),
        .rs       (tx_rs),
        .tx_byte  (tx_byte),
        .done     (tx_done),
        .lcd_clk  (lcd_clk),
        .lcd_cs   (lcd_cs),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_spi_screen.sv
// tb_spi_screen
// Bench for spi_screen with shortened delays and a 240x5 frame so that the
// pattern wraps in both directions. A pin-level SPI decoder rebuilds every
// {rs,byte} frame, and each decoded byte is set against a reference stream
// computed from the pattern arithmetic and the init command list.
module tb_spi_screen;

    localparam int T_RESET   = 40;
    localparam int T_PREPARE = 30;
    localparam int T_SNOOZE  = 25;
    localparam int H_PIX     = 240;
    localparam int V_PIX     = 5;
    localparam int FULL_RUN  = 18 + 2 * H_PIX * V_PIX + 4;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data;

    always #5 clk = ~clk;

    spi_screen #(
        .T_RESET   (T_RESET),
        .T_PREPARE (T_PREPARE),
        .T_SNOOZE  (T_SNOOZE),
        .H_PIX     (H_PIX),
        .V_PIX     (V_PIX)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .lcd_resetn (lcd_resetn),
        .lcd_clk    (lcd_clk),
        .lcd_cs     (lcd_cs),
        .lcd_rs     (lcd_rs),
        .lcd_data   (lcd_data)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Expected init command list, {rs,byte}.
    bit [8:0] rom_ref [17] = '{9'h036, 9'h170, 9'h03A, 9'h105, 9'h021, 9'h02A,
                               9'h100, 9'h128, 9'h101, 9'h117, 9'h02B, 9'h100,
                               9'h135, 9'h100, 9'h1BB, 9'h029, 9'h02C};

    typedef struct {
        string    name;
        int       idx;
        bit [8:0] expect_word;
    } vec_t;
    vec_t vecs[$];

    // Decoder state: frames are rebuilt from the pins at every falling clk.
    bit [8:0] dec_q[$];
    bit       shape_q[$];
    int       start_q[$];
    int       cyc = 0;
    int       idle_err = 0;
    int       resetn_err = 0;
    bit       in_frame = 0;
    bit       lcd_up = 0;
    int       f_len, f_edges;
    bit [7:0] f_byte;
    bit       f_rs, f_rs_ok;
    logic     prev_sck = 1'b0;

    // SPI frame decoder: captures MOSI on each rising SCK while CS is low and
    // records frame length, edge count and D/C stability. A frame cut short by
    // a controller reset is discarded.
    always @(negedge clk) begin
        cyc++;
        if (resetn !== 1'b0) begin
            in_frame = 0;
            lcd_up = 0;
        end else begin
            if (lcd_resetn === 1'b1) lcd_up = 1;
            else if (lcd_up) resetn_err++;
            if (lcd_cs === 1'b0) begin
                if (!in_frame) begin
                    in_frame = 1;
                    f_len = 0;
                    f_edges = 0;
                    f_byte = 8'h00;
                    f_rs = lcd_rs;
                    f_rs_ok = 1;
                    start_q.push_back(cyc);
                end
                f_len++;
                if (lcd_rs !== f_rs) f_rs_ok = 0;
                if (lcd_clk === 1'b1 && prev_sck === 1'b0) begin
                    f_byte = {f_byte[6:0], lcd_data};
                    f_edges++;
                end
            end else begin
                if (in_frame) begin
                    dec_q.push_back({f_rs, f_byte});
                    shape_q.push_back(f_len == 16 && f_edges == 8 && f_rs_ok);
                    in_frame = 0;
                end
                if (lcd_clk !== 1'b0) idle_err++;
            end
        end
        prev_sck = lcd_clk;
    end

    // Reference stream entry: SLPOUT, the init list, then two bytes per pixel
    // in raster order with the frame wrapping back to the origin.
    function automatic bit [8:0] model_entry(input int idx);
        int p, x, y, pix;
        if (idx == 0) return 9'h011;
        if (idx <= 17) return rom_ref[idx - 1];
        p = (idx - 18) / 2;
        x = p % H_PIX;
        y = (p / H_PIX) % V_PIX;
        pix = ((x / 8) % 32) * 2048 + ((y / 4) % 64) * 32 + ((x ^ y) % 32);
        if ((idx - 18) % 2 == 0) return {1'b1, 8'(pix / 256)};
        return {1'b1, 8'(pix % 256)};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input int cycles);
        resetn = rst;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Counts rising edges until the chosen pin (0 = lcd_resetn, 1 = lcd_cs)
    // shows the wanted level one step after the edge.
    task automatic countUntil(input string name, input int which, input logic level,
                              input int budget, output int n);
        logic v;
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            v = (which == 0) ? lcd_resetn : lcd_cs;
            if (v === level) return;
        end
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: timed out after %0d cycles, expected pin level %0b", name, budget, level);
    endtask

    task automatic waitBytes(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (dec_q.size() < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (dec_q.size() < target) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: got %0d bytes, expected at least %0d", name, dec_q.size(), target);
        end
    endtask

    task automatic compareStream(input string tag, input int count);
        for (int i = 0; i < count && i < dec_q.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), int'(dec_q[i]), int'(model_entry(i)));
            checkOutput($sformatf("%s_shape%0d", tag, i), int'(shape_q[i]), 1);
            if (i == 1)
                checkOutput($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], 17 + T_SNOOZE);
            else if (i > 1)
                checkOutput($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], 17);
        end
    endtask

    task automatic addVec(input string name, input int idx, input bit [8:0] w);
        vec_t v;
        v.name = name;
        v.idx = idx;
        v.expect_word = w;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, k;

        // Hand-derived checkpoints: decoded byte index -> expected {rs,byte}.
        addVec("slpout",     0,    9'h011);
        addVec("madctl",     1,    9'h036);
        addVec("madctl_par", 2,    9'h170);
        addVec("dispon",     16,   9'h029);
        addVec("ramwr",      17,   9'h02C);
        addVec("p0_hi",      18,   9'h100);
        addVec("p0_lo",      19,   9'h100);
        addVec("p1_hi",      20,   9'h100);
        addVec("p1_lo",      21,   9'h101);
        addVec("p8_hi",      34,   9'h108);
        addVec("p8_lo",      35,   9'h108);
        addVec("p239_hi",    496,  9'h1E8);
        addVec("p239_lo",    497,  9'h10F);
        addVec("p240_hi",    498,  9'h100);
        addVec("p240_lo",    499,  9'h101);
        addVec("p1000_hi",   2018, 9'h128);
        addVec("p1000_lo",   2019, 9'h12C);
        addVec("p1199_lo",   2417, 9'h12B);
        addVec("wrap_hi",    2418, 9'h100);
        addVec("wrap_lo",    2419, 9'h100);

        $display("[TB] reset hold");
        applyStimulus(1'b1, 10);
        checkOutput("rst_lcd_resetn", lcd_resetn, 0);
        checkOutput("rst_cs", lcd_cs, 1);
        checkOutput("rst_sck", lcd_clk, 0);
        checkOutput("rst_rs", lcd_rs, 1);
        checkOutput("rst_data", lcd_data, 0);

        #1;
        resetn = 1'b0;
        countUntil("t_reset", 0, 1'b1, T_RESET + 20, n);
        checkOutput("t_reset", n, T_RESET);
        countUntil("t_prepare", 1, 1'b0, T_PREPARE + 20, n);
        checkOutput("t_prepare", n, T_PREPARE);
        countUntil("slpout_end", 1, 1'b1, 40, n);
        checkOutput("slpout_len", n, 16);
        countUntil("t_snooze", 1, 1'b0, T_SNOOZE + 20, n);
        checkOutput("t_snooze", n - 1, T_SNOOZE);

        $display("[TB] streaming first run");
        waitBytes("first_run", FULL_RUN, FULL_RUN * 17 + 500);
        compareStream("run1", FULL_RUN);
        foreach (vecs[i]) begin
            if (vecs[i].idx < dec_q.size())
                checkOutput(vecs[i].name, int'(dec_q[vecs[i].idx]), int'(vecs[i].expect_word));
        end

        // Abort at a random point inside a pixel byte.
        waitBytes("pre_abort", dec_q.size() + $urandom_range(1, 20), 500);
        countUntil("abort_frame", 1, 1'b0, 40, n);
        k = $urandom_range(0, 14);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_abort_cs", lcd_cs, 0);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_cs", lcd_cs, 1);
        checkOutput("abort_lcd_resetn", lcd_resetn, 0);
        checkOutput("abort_sck", lcd_clk, 0);
        checkOutput("abort_rs", lcd_rs, 1);
        checkOutput("abort_data", lcd_data, 0);
        applyStimulus(1'b1, $urandom_range(1, 8));
        dec_q.delete();
        shape_q.delete();
        start_q.delete();

        $display("[TB] second run after abort");
        #1;
        resetn = 1'b0;
        countUntil("t_reset2", 0, 1'b1, T_RESET + 20, n);
        checkOutput("t_reset2", n, T_RESET);
        countUntil("t_prepare2", 1, 1'b0, T_PREPARE + 20, n);
        checkOutput("t_prepare2", n, T_PREPARE);
        waitBytes("second_run", 22, 22 * 17 + T_SNOOZE + 200);
        compareStream("run2", 22);

        checkOutput("idle_sck", idle_err, 0);
        checkOutput("lcd_resetn_held", resetn_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
